// File: rtl/irq_handler_pkg.sv
// Shared definitions for the machine-mode external-interrupt trap handler:
// FSM state encoding, CSR addresses, mstatus/mie bit positions and the
// mstatus rewrite helpers used on trap entry and on mret.
package irq_handler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        E_MEPC    = 3'd1,
        E_MCAUSE  = 3'd2,
        E_MSTATUS = 3'd3,
        E_JUMP    = 3'd4,
        R_MSTATUS = 3'd5,
        R_JUMP    = 3'd6
    } irq_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MIE_BIT  = 3;   // mstatus.MIE
    localparam int MPIE_BIT = 7;   // mstatus.MPIE
    localparam int MEIE_BIT = 11;  // mie.MEIE

    // Trap entry: MPIE <- MIE, MIE <- 0, everything else untouched.
    function automatic logic [31:0] entry_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r           = m;
        r[MPIE_BIT] = m[MIE_BIT];
        r[MIE_BIT]  = 1'b0;
        return r;
    endfunction

    // mret: MIE <- MPIE, MPIE <- 1, everything else untouched.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r           = m;
        r[MIE_BIT]  = m[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_handler.sv
// Machine-mode external-interrupt handler. Sequences the CSR writes for
// trap entry (mepc, mcause, mstatus, then jump + claim) and for mret
// (mstatus, then jump to mepc) while freezing the pipeline via hold_o.
// Optional build macro IRQ_HANDLER_VECTORED_EN enables vectored entry
// (mtvec mode 2'b01 -> base + ID*4); without it entry always jumps to base.
module irq_handler
    import irq_handler_pkg::*;
#(
    parameter logic [31:0] IRQ_CAUSE = 32'h8000000B,
    parameter int          ID_W      = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            irq_i,
    input  logic [ID_W-1:0] irq_id_i,
    input  logic            inst_valid_i,
    input  logic            stall_i,
    input  logic [31:0]     inst_addr_i,
    input  logic            mret_i,
    input  logic [31:0]     mstatus_i,
    input  logic [31:0]     mie_i,
    input  logic [31:0]     mtvec_i,
    input  logic [31:0]     mepc_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [31:0]     csr_wdata_o,
    output logic            hold_o,
    output logic            jump_o,
    output logic [31:0]     jump_addr_o,
    output logic            claim_o,
    output logic [ID_W-1:0] claim_id_o
);

    irq_state_e      state_q;
    logic [31:0]     pc_q;
    logic [ID_W-1:0] id_q;

    logic            csr_we_q;
    logic [11:0]     csr_waddr_q;
    logic [31:0]     csr_wdata_q;
    logic            jump_q;
    logic [31:0]     jump_addr_q;
    logic            claim_q;
    logic [ID_W-1:0] claim_id_q;

    logic            in_idle;
    logic            commit_ok;
    logic            accept_mret;
    logic            accept_irq;
    logic [31:0]     entry_addr;

    // Acceptance qualifiers; mret wins over a simultaneous interrupt.
    assign in_idle     = (state_q == IDLE);
    assign commit_ok   = in_idle && inst_valid_i && !stall_i;
    assign accept_mret = commit_ok && mret_i;
    assign accept_irq  = commit_ok && !mret_i && irq_i
                         && mstatus_i[MIE_BIT] && mie_i[MEIE_BIT];

`ifdef IRQ_HANDLER_VECTORED_EN
    // Trap entry target: vectored offset by latched ID when mtvec mode is 01.
    always_comb begin
        entry_addr = {mtvec_i[31:2], 2'b00};
        if (mtvec_i[1:0] == 2'b01) begin
            entry_addr = entry_addr + (32'(id_q) << 2);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:0], pc_q};
`else
    assign entry_addr = {mtvec_i[31:2], 2'b00};

    // Mode bits are irrelevant in direct-only builds; the latched PC is kept
    // as architectural state even though the mepc write is taken at accept.
    logic unused_bits;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:0], mtvec_i[1:0], pc_q};
`endif

    // Hold is asserted in the accept cycle and throughout every sequence;
    // gated by reset so all outputs read 0 while reset is applied.
    assign hold_o = rst_ni && (!in_idle || accept_mret || accept_irq);

    // Sequencer with registered outputs: each branch loads the strobes and
    // data that the next state presents, so outputs default back to 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            id_q        <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
            claim_q     <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
            claim_q     <= 1'b0;
            claim_id_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (accept_mret) begin
                        state_q     <= R_MSTATUS;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MSTATUS;
                        csr_wdata_q <= mret_mstatus(mstatus_i);
                    end else if (accept_irq) begin
                        state_q     <= E_MEPC;
                        pc_q        <= inst_addr_i;
                        id_q        <= irq_id_i;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_MEPC;
                        csr_wdata_q <= inst_addr_i;
                    end
                end
                E_MEPC: begin
                    state_q     <= E_MCAUSE;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MCAUSE;
                    csr_wdata_q <= IRQ_CAUSE;
                end
                E_MCAUSE: begin
                    state_q     <= E_MSTATUS;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_MSTATUS;
                    csr_wdata_q <= entry_mstatus(mstatus_i);
                end
                E_MSTATUS: begin
                    state_q     <= E_JUMP;
                    jump_q      <= 1'b1;
                    jump_addr_q <= entry_addr;
                    claim_q     <= 1'b1;
                    claim_id_q  <= id_q;
                end
                E_JUMP: begin
                    state_q <= IDLE;
                end
                R_MSTATUS: begin
                    state_q     <= R_JUMP;
                    jump_q      <= 1'b1;
                    jump_addr_q <= mepc_i;
                end
                R_JUMP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign csr_we_o    = csr_we_q;
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;
    assign jump_o      = jump_q;
    assign jump_addr_o = jump_addr_q;
    assign claim_o     = claim_q;
    assign claim_id_o  = claim_id_q;

endmodule
